ahb_ram_responder: RTL and testbench

- AHB-Lite subordinate with word-addressed RAM; the responder end of the hardisc instruction/data buses, including the custom protection sideband (hparity, hwchecksum, hrchecksum).
- Checks address/control parity and write-data checksum, and generates the read-data checksum.
- Answers every transfer with OKAY or a two-cycle ERROR response.
- Used as boot/data memory in system-level benches and small SoC builds.

---
 rtl/ahb_ram_responder.sv | 185 ++++++++++++++++++
 tb/tb_ahb_ram_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_responder.sv
// rtl/ahb_ram_responder.sv - AHB-Lite RAM subordinate with parity/checksum protection sideband
//
// Purpose: word-addressed RAM (2^ADDR_W x 32) answering AHB-Lite transfers with
// OKAY (optionally after WAIT_STATES wait cycles) or a two-cycle ERROR. Checks
// even parity over address/control, checks the (39,32) SEC-DED checksum of
// write data and generates the checksum of read data.
//
// Ports:
//   s_clk_i, s_resetn_i          clock, asynchronous active-low reset
//   s_hsel_i .. s_hready_i       AHB-Lite address/control inputs (HREADYIN)
//   s_hwdata_i, s_hwchecksum_i   write data and its checksum (data phase)
//   s_hparity_i                  address/control parity (address phase)
//   s_hrdata_o, s_hrchecksum_o   read data and its checksum (zero outside read data phases)
//   s_hready_o, s_hresp_o        transfer done / error response
//   s_perr_o, s_cerr_o           one-cycle pulses: parity error / write checksum error
module ahb_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [31:0] s_hwdata_i,
  input  logic [2:0]  s_hburst_i,
  input  logic        s_hmastlock_i,
  input  logic [3:0]  s_hprot_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic        s_hready_i,
  input  logic [6:0]  s_hwchecksum_i,
  input  logic [5:0]  s_hparity_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hready_o,
  output logic        s_hresp_o,
  output logic [6:0]  s_hrchecksum_o,
  output logic        s_perr_o,
  output logic        s_cerr_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  // Hamming SEC-DED: data bits occupy the non-power-of-two codeword positions
  // 3,5,6,7,9..38; check bit k covers positions with bit k set; bit 6 is the
  // overall parity of data and the six Hamming bits.
  function automatic logic [6:0] ecc_encode(input logic [31:0] d);
    logic [6:0] c;
    logic [5:0] pos;
    c   = '0;
    pos = 6'd3;
    for (int i = 0; i < 32; i++) begin
      if ((pos & (pos - 6'd1)) == 6'd0) pos = pos + 6'd1;
      for (int k = 0; k < 6; k++) c[k] = c[k] ^ (d[i] & pos[k]);
      pos = pos + 6'd1;
    end
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

  logic [1:0]        state;
  logic [2:0]        wait_cnt;
  logic              dp_valid;   // an OKAY-bound data phase is in progress
  logic              dp_write;
  logic [ADDR_W-1:0] dp_addr;
  logic [1:0]        dp_size;
  logic [1:0]        dp_off;
  logic              perr_q;
  logic              cerr_q;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic       accept;
  logic [5:0] par_calc;
  logic       par_err;
  logic       align_err;
  logic       flag_err;
  logic       dp_end;
  logic       wr_ck_bad;
  logic       wr_en;
  logic       rd_done;
  logic [3:0] be;

  assign accept = s_hsel_i & s_hready_i & s_htrans_i[1];

  assign par_calc = {^{s_htrans_i, s_hprot_i},
                     ^{s_hwrite_i, s_hsize_i, s_hburst_i, s_hmastlock_i},
                     ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                     ^s_haddr_i[15:8],  ^s_haddr_i[7:0]};
  assign par_err  = (par_calc != s_hparity_i);

  assign align_err = (s_hsize_i > 3'd2) ||
                     ((s_hsize_i == 3'd1) && s_haddr_i[0]) ||
                     ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'b00));
  assign flag_err  = par_err | align_err;

  // The cycle in which an OKAY data phase would complete.
  assign dp_end    = dp_valid & ((state == ST_IDLE) |
                                 ((state == ST_WAIT) & (wait_cnt == WS)));
  // A bad write checksum turns that completion cycle into ERR1.
  assign wr_ck_bad = dp_end & dp_write & (ecc_encode(s_hwdata_i) != s_hwchecksum_i);
  assign wr_en     = dp_end & dp_write & ~wr_ck_bad;
  assign rd_done   = dp_end & ~dp_write;

  always_comb begin
    s_hready_o = 1'b1;
    s_hresp_o  = 1'b0;
    case (state)
      ST_IDLE: s_hready_o = ~wr_ck_bad;
      ST_WAIT: s_hready_o = (wait_cnt == WS) & ~wr_ck_bad;
      ST_ERR1: begin
        s_hready_o = 1'b0;
        s_hresp_o  = 1'b1;
      end
      ST_ERR2: s_hresp_o = 1'b1;
      default: s_hready_o = 1'b1;
    endcase
    if (wr_ck_bad) s_hresp_o = 1'b1;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
      dp_off   <= '0;
      perr_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      perr_q <= s_hready_o & accept & par_err;
      cerr_q <= wr_ck_bad;
      if (s_hready_o) begin
        wait_cnt <= '0;
        if (accept) begin
          dp_write <= s_hwrite_i;
          dp_addr  <= s_haddr_i[ADDR_W+1:2];
          dp_size  <= s_hsize_i[1:0];
          dp_off   <= s_haddr_i[1:0];
          dp_valid <= ~flag_err;
          if (flag_err)      state <= ST_ERR1;
          else if (WS != 0)  state <= ST_WAIT;
          else               state <= ST_IDLE;
        end else begin
          dp_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      end else if (wr_ck_bad || (state == ST_ERR1)) begin
        dp_valid <= 1'b0;
        state    <= ST_ERR2;
      end else begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    case (dp_size)
      2'd0:    be = 4'b0001 << dp_off;
      2'd1:    be = dp_off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[dp_addr][8*b +: 8] <= s_hwdata_i[8*b +: 8];
      end
    end
  end

  assign s_hrdata_o     = rd_done ? mem[dp_addr] : 32'd0;
  assign s_hrchecksum_o = ecc_encode(s_hrdata_o);
  assign s_perr_o       = perr_q;
  assign s_cerr_o       = cerr_q;

endmodule

// File: tb/tb_ahb_ram_responder.sv
// tb/tb_ahb_ram_responder.sv - two-subordinate AHB bench (0 and 3 wait states) with scoreboard
module tb_ahb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hburst, hsize;
  logic        hmastlock, hwrite;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [6:0]  hwchecksum;
  logic [5:0]  hparity;

  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, resp_a, resp_b;
  logic [6:0]  rck_a, rck_b;
  logic        perr_a, perr_b, cerr_a, cerr_b;

  logic        dp_sel_b;
  logic        hready, hresp, perr, cerr;
  logic [31:0] hrdata;
  logic [6:0]  hrck;

  always #5 clk = ~clk;

  assign hready = dp_sel_b ? ready_b : ready_a;
  assign hresp  = dp_sel_b ? resp_b  : resp_a;
  assign hrdata = dp_sel_b ? rdata_b : rdata_a;
  assign hrck   = dp_sel_b ? rck_b   : rck_a;
  assign perr   = perr_a | perr_b;
  assign cerr   = cerr_a | cerr_b;

  // Data-phase mux select of the bus fabric.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dp_sel_b <= 1'b0;
    else if (hready) dp_sel_b <= hsel_b;
  end

  ahb_ram_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_a (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(hsel_a), .s_haddr_i(haddr),
    .s_hwdata_i(hwdata), .s_hburst_i(hburst), .s_hmastlock_i(hmastlock),
    .s_hprot_i(hprot), .s_hsize_i(hsize), .s_htrans_i(htrans), .s_hwrite_i(hwrite),
    .s_hready_i(hready), .s_hwchecksum_i(hwchecksum), .s_hparity_i(hparity),
    .s_hrdata_o(rdata_a), .s_hready_o(ready_a), .s_hresp_o(resp_a),
    .s_hrchecksum_o(rck_a), .s_perr_o(perr_a), .s_cerr_o(cerr_a));

  ahb_ram_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut_b (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_hsel_i(hsel_b), .s_haddr_i(haddr),
    .s_hwdata_i(hwdata), .s_hburst_i(hburst), .s_hmastlock_i(hmastlock),
    .s_hprot_i(hprot), .s_hsize_i(hsize), .s_htrans_i(htrans), .s_hwrite_i(hwrite),
    .s_hready_i(hready), .s_hwchecksum_i(hwchecksum), .s_hparity_i(hparity),
    .s_hrdata_o(rdata_b), .s_hready_o(ready_b), .s_hresp_o(resp_b),
    .s_hrchecksum_o(rck_b), .s_perr_o(perr_b), .s_cerr_o(cerr_b));

  typedef struct {
    bit          sel_b;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [5:0]  pflip;
    logic [6:0]  cflip;
    bit          exp_err;
    bit          exp_perr;
    bit          exp_cerr;
    int          exp_waits;
    logic [31:0] exp_rdata;
    string       tag;
  } xfer_t;

  xfer_t       cmd_q[$];
  xfer_t       exp_q[$];
  logic [31:0] ref_mem [0:2047];
  int          n_vec  = 0;
  int          n_miss = 0;

  // Reference encoder: build the 38-position Hamming codeword, then the
  // syndrome is the XOR of the positions holding a one.
  function automatic logic [6:0] ecc_ref(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  syn;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 38; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        cw[p] = d[j];
        j++;
      end
    end
    syn = '0;
    for (int p = 1; p <= 38; p++) if (cw[p]) syn = syn ^ 6'(p);
    return {(^d) ^ (^syn), syn};
  endfunction

  function automatic logic [5:0] par_ref(input logic [31:0] a, input logic w,
                                         input logic [2:0] sz, input logic [2:0] b,
                                         input logic ml, input logic [1:0] t,
                                         input logic [3:0] p);
    return {^{t, p}, ^{w, sz, b, ml}, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    htrans = 2'b00; hburst = 3'd0; hmastlock = 1'b0; hprot = 4'b0011;
    hparity = par_ref(haddr, hwrite, hsize, hburst, hmastlock, htrans, hprot);
  endtask

  task automatic drive_addr(input xfer_t c);
    hsel_a = !c.sel_b; hsel_b = c.sel_b; haddr = c.addr; hwrite = c.wr;
    hsize = c.size; htrans = 2'b10; hburst = 3'd0; hmastlock = 1'b0; hprot = 4'b0011;
    hparity = par_ref(haddr, hwrite, hsize, hburst, hmastlock, htrans, hprot) ^ c.pflip;
  endtask

  task automatic add(input bit sel_b, input bit wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata,
                     input logic [5:0] pflip, input logic [6:0] cflip, input string tag);
    xfer_t c;
    c.sel_b = sel_b; c.wr = wr; c.addr = addr; c.size = size; c.wdata = wdata;
    c.pflip = pflip; c.cflip = cflip; c.tag = tag;
    c.exp_err = 1'b0; c.exp_perr = 1'b0; c.exp_cerr = 1'b0; c.exp_waits = 0;
    c.exp_rdata = '0;
    cmd_q.push_back(c);
  endtask

  // Expected outcome of a transfer at the moment the bus accepts it; the
  // reference memory is updated here so later pipelined reads see the data.
  task automatic push_expected(input xfer_t c_in);
    xfer_t c;
    bit    align, acc_err, ck_bad;
    int    wi;
    logic [3:0] be;
    c     = c_in;
    wi    = {c.sel_b, c.addr[11:2]};
    align = (c.size > 3'd2) || (c.size == 3'd1 && c.addr[0]) ||
            (c.size == 3'd2 && c.addr[1:0] != 2'b00);
    c.exp_perr  = (c.pflip != 6'd0);
    acc_err     = c.exp_perr || align;
    ck_bad      = c.wr && (c.cflip != 7'd0);
    c.exp_err   = acc_err || ck_bad;
    c.exp_cerr  = !acc_err && ck_bad;
    c.exp_waits = acc_err ? 1 : ((c.sel_b ? 3 : 0) + (ck_bad ? 1 : 0));
    c.exp_rdata = (!c.wr && !c.exp_err) ? ref_mem[wi] : 32'd0;
    if (c.wr && !c.exp_err) begin
      be = (c.size == 3'd0) ? (4'b0001 << c.addr[1:0]) :
           (c.size == 3'd1) ? (c.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[wi][8*b +: 8] = c.wdata[8*b +: 8];
    end
    exp_q.push_back(c);
  endtask

  // Pipelined master: each cycle drives the current data phase and the next
  // address phase, scores completions and accepts new transfers on HREADY.
  task automatic run_cmds();
    int    guard = 0;
    int    waits = 0;
    int    perr_n = 0;
    int    cerr_n = 0;
    bit    err1_seen = 1'b0;
    xfer_t cur;
    while ((cmd_q.size() != 0 || exp_q.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (exp_q.size() != 0 && exp_q[0].wr) begin
        hwdata     = exp_q[0].wdata;
        hwchecksum = ecc_ref(exp_q[0].wdata) ^ exp_q[0].cflip;
      end else begin
        hwdata = '0; hwchecksum = '0;
      end
      if (cmd_q.size() != 0) drive_addr(cmd_q[0]);
      else drive_idle();
      #1;
      if (exp_q.size() != 0) begin
        perr_n += int'(perr);
        cerr_n += int'(cerr);
        if (!hready) begin
          waits++;
          if (hresp) err1_seen = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          check({cur.tag, ".resp"},  32'(hresp),     32'(cur.exp_err));
          check({cur.tag, ".rdata"}, hrdata,         cur.exp_rdata);
          check({cur.tag, ".rck"},   32'(hrck),      32'(ecc_ref(cur.exp_rdata)));
          check({cur.tag, ".waits"}, 32'(waits),     32'(cur.exp_waits));
          check({cur.tag, ".err1"},  32'(err1_seen), 32'(cur.exp_err));
          check({cur.tag, ".perr"},  32'(perr_n),    32'(cur.exp_perr));
          check({cur.tag, ".cerr"},  32'(cerr_n),    32'(cur.exp_cerr));
          waits = 0; perr_n = 0; cerr_n = 0; err1_seen = 1'b0;
        end
      end
      if (hready && cmd_q.size() != 0) push_expected(cmd_q.pop_front());
    end
    if (guard >= 400) begin
      n_vec++;
      n_miss++;
      $error("FAIL timeout: observed %0d pending expected 0", cmd_q.size() + exp_q.size());
      cmd_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    drive_idle();
    hwdata = '0; hwchecksum = '0;
  endtask

  initial begin
    xfer_t bad;
    rst_n = 1'b0;
    drive_idle();
    hwdata = '0; hwchecksum = '0;
    #1;
    check("rst.hready", 32'(ready_a), 32'd1);
    check("rst.hresp",  32'(resp_a),  32'd0);
    check("rst.hrdata", rdata_a,      32'd0);
    check("rst.hrck",   32'(rck_a),   32'd0);
    check("rst.perr",   32'(perr_a),  32'd0);
    check("rst.cerr",   32'(cerr_a),  32'd0);
    check("rst.b_hready", 32'(ready_b), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait subordinate: word access, byte/halfword lanes, errors, aliasing.
    add(0, 1, 32'h04, 3'd2, 32'hDEADBEEF, 6'd0, 7'd0, "wr_deadbeef");
    add(0, 0, 32'h04, 3'd2, 32'h0,        6'd0, 7'd0, "rd_deadbeef");
    add(0, 1, 32'h00, 3'd2, 32'h11111111, 6'd0, 7'd0, "wr_w0");
    add(0, 1, 32'h04, 3'd2, 32'h00000000, 6'd0, 7'd0, "wr_zero");
    add(0, 1, 32'h06, 3'd0, 32'h00AA0000, 6'd0, 7'd0, "wr_byte6");
    add(0, 0, 32'h04, 3'd2, 32'h0,        6'd0, 7'd0, "rd_byte6");
    add(0, 1, 32'h03, 3'd1, 32'hFFFFFFFF, 6'd0, 7'd0, "wr_half_misal");
    add(0, 0, 32'h00, 3'd2, 32'h0,        6'd0, 7'd0, "rd_w0_intact");
    add(0, 0, 32'h10, 3'd2, 32'h0,        6'b000100, 7'd0, "rd_par_err");
    add(0, 0, 32'h04, 3'd2, 32'h0,        6'd0, 7'd0, "rd_after_err2");
    add(0, 1, 32'h04, 3'd2, 32'h12345678, 6'd0, 7'b0000001, "wr_ck_err");
    add(0, 0, 32'h04, 3'd2, 32'h0,        6'd0, 7'd0, "rd_prior");
    add(0, 1, 32'h1020, 3'd2, 32'hCAFEF00D, 6'd0, 7'd0, "wr_alias");
    add(0, 1, 32'h22, 3'd1, 32'hBEEF0000, 6'd0, 7'd0, "wr_half22");
    add(0, 0, 32'h20, 3'd2, 32'h0,        6'd0, 7'd0, "rd_alias");
    add(0, 1, 32'h08, 3'd3, 32'h0,        6'd0, 7'd0, "wr_size3");
    run_cmds();

    // Three-wait-state subordinate, interleaved with the zero-wait one.
    add(1, 1, 32'h40, 3'd2, 32'h5A5A1234, 6'd0, 7'd0, "b_wr");
    add(1, 0, 32'h40, 3'd2, 32'h0,        6'd0, 7'd0, "b_rd");
    add(1, 1, 32'h41, 3'd0, 32'h0000C300, 6'd0, 7'd0, "b_wr_byte");
    add(1, 0, 32'h40, 3'd2, 32'h0,        6'd0, 7'd0, "b_rd_byte");
    add(0, 0, 32'h04, 3'd2, 32'h0,        6'd0, 7'd0, "a_rd_mix");
    add(1, 1, 32'h40, 3'd2, 32'h0BADF00D, 6'd0, 7'b1000000, "b_wr_ck_err");
    add(1, 0, 32'h40, 3'd2, 32'h0,        6'd0, 7'd0, "b_rd_prior");
    add(1, 0, 32'h44, 3'd2, 32'h0,        6'b100000, 7'd0, "b_rd_par_err");
    run_cmds();

    // Reset asserted while the zero-wait subordinate sits in ERR1.
    bad.sel_b = 1'b0; bad.wr = 1'b0; bad.addr = 32'h10; bad.size = 3'd2;
    bad.pflip = 6'b000100;
    @(negedge clk);
    drive_addr(bad);
    @(negedge clk);
    drive_idle();
    #1;
    check("err1.hready", 32'(ready_a), 32'd0);
    check("err1.hresp",  32'(resp_a),  32'd1);
    check("err1.perr",   32'(perr_a),  32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.hready", 32'(ready_a), 32'd1);
    check("rstmid.hresp",  32'(resp_a),  32'd0);
    check("rstmid.perr",   32'(perr_a),  32'd0);
    check("rstmid.hrdata", rdata_a,      32'd0);
    check("rstmid.hrck",   32'(rck_a),   32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    add(0, 0, 32'h04, 3'd2, 32'h0, 6'd0, 7'd0, "post_rst_rd4");
    add(0, 0, 32'h20, 3'd2, 32'h0, 6'd0, 7'd0, "post_rst_rd20");
    add(1, 0, 32'h40, 3'd2, 32'h0, 6'd0, 7'd0, "post_rst_b_rd40");
    run_cmds();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
